i2c_bus_arbiter: RTL and testbench

- Shares one byte-level I2C master engine between NREQ requesters.
- Arbitrates round-robin, launches one single-byte transaction per grant, and watches the engine's busy/done handshake.
- Returns read data and status to the winning requester.
- Sits between local client logic (sensor/config pollers) and the I2C master engine that drives scl/sda toward the slave devices.

---
 rtl/i2c_bus_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter that shares one byte-level I2C master engine between
// NREQ requesters. Each grant launches one single-byte transaction, watches
// the engine's busy/done handshake, and returns read data and status to the
// winner. A watchdog timer aborts transactions the engine never completes.
//
// Handshakes:
//   Client side: req[i] is a level. The arbiter answers with gnt[i], held for
//   the whole transaction, and a one-cycle done[i] while rdata/nack/tout are
//   valid. The requester drops req[i] on its done. req_* fields are sampled
//   only on the granting edge.
//   Engine side: m_start pulses for one cycle with m_addr/m_rw/m_wdata stable.
//   The engine raises m_busy and later pulses m_done for one cycle, with
//   m_ack_err and m_rdata valid in that same cycle. m_abort pulses for one
//   cycle when the watchdog expires.
module i2c_bus_arbiter #(
  parameter int NREQ    = 4,
  parameter int ADDR_W  = 7,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ-1:0]        req_rw,
  input  logic [NREQ*8-1:0]      req_wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic [7:0]             rdata,
  output logic                   nack,
  output logic                   tout,
  output logic                   m_start,
  output logic                   m_abort,
  output logic [ADDR_W-1:0]      m_addr,
  output logic                   m_rw,
  output logic [7:0]             m_wdata,
  input  logic                   m_busy,
  input  logic                   m_done,
  input  logic                   m_ack_err,
  input  logic [7:0]             m_rdata,
  output logic                   busy,
  output logic [2:0]             state
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LAUNCH    = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_RESP      = 3'd4;

  logic [2:0]        state_q,   state_d;
  logic [PTR_W-1:0]  ptr_q,     ptr_d;
  logic [PTR_W-1:0]  idx_q,     idx_d;
  logic [TMR_W-1:0]  timer_q,   timer_d;
  logic [NREQ-1:0]   gnt_q,     gnt_d;
  logic [NREQ-1:0]   done_q,    done_d;
  logic [7:0]        rdata_q,   rdata_d;
  logic              nack_q,    nack_d;
  logic              tout_q,    tout_d;
  logic              m_start_q, m_start_d;
  logic              m_abort_q, m_abort_d;
  logic [ADDR_W-1:0] m_addr_q,  m_addr_d;
  logic              m_rw_q,    m_rw_d;
  logic [7:0]        m_wdata_q, m_wdata_d;
  logic              busy_q,    busy_d;

  logic              arb_found;
  logic [PTR_W-1:0]  arb_idx;

  // Round-robin search: first set req bit starting at ptr and wrapping.
  always_comb begin
    logic [PTR_W:0] cand;
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(NREQ)) begin
        cand = cand - (PTR_W+1)'(NREQ);
      end
      if (!arb_found && req[cand[PTR_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Transaction FSM, watchdog timer and result capture.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    rdata_d   = rdata_q;
    nack_d    = nack_q;
    tout_d    = tout_q;
    m_start_d = 1'b0;
    m_abort_d = 1'b0;
    m_addr_d  = m_addr_q;
    m_rw_d    = m_rw_q;
    m_wdata_d = m_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          state_d          = ST_LAUNCH;
          idx_d            = arb_idx;
          gnt_d            = '0;
          gnt_d[arb_idx]   = 1'b1;
          m_addr_d         = req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
          m_rw_d           = req_rw[arb_idx];
          m_wdata_d        = req_wdata[int'(arb_idx)*8 +: 8];
          timer_d          = '0;
          // m_start is registered, so it is high during the LAUNCH cycle.
          m_start_d        = 1'b1;
        end
      end

      ST_LAUNCH: begin
        timer_d = timer_q + 1'b1;
        state_d = ST_WAIT_BUSY;
      end

      ST_WAIT_BUSY, ST_WAIT_DONE: begin
        if (m_done) begin
          // Completion wins over both a simultaneous busy rise and timeout.
          state_d = ST_RESP;
          done_d  = gnt_q;
          nack_d  = m_ack_err;
          tout_d  = 1'b0;
          rdata_d = (m_rw_q && !m_ack_err) ? m_rdata : 8'h00;
        end else if (timer_q == TMR_W'(TIMEOUT)) begin
          state_d   = ST_RESP;
          done_d    = gnt_q;
          m_abort_d = 1'b1;
          nack_d    = 1'b0;
          tout_d    = 1'b1;
          rdata_d   = 8'h00;
        end else begin
          timer_d = timer_q + 1'b1;
          if (state_q == ST_WAIT_BUSY && m_busy) begin
            state_d = ST_WAIT_DONE;
          end
        end
      end

      ST_RESP: begin
        gnt_d   = '0;
        ptr_d   = (idx_q == PTR_W'(NREQ - 1)) ? '0 : idx_q + 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any transaction silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      timer_q   <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      nack_q    <= 1'b0;
      tout_q    <= 1'b0;
      m_start_q <= 1'b0;
      m_abort_q <= 1'b0;
      m_addr_q  <= '0;
      m_rw_q    <= 1'b0;
      m_wdata_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      nack_q    <= nack_d;
      tout_q    <= tout_d;
      m_start_q <= m_start_d;
      m_abort_q <= m_abort_d;
      m_addr_q  <= m_addr_d;
      m_rw_q    <= m_rw_d;
      m_wdata_q <= m_wdata_d;
      busy_q    <= busy_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign nack    = nack_q;
  assign tout    = tout_q;
  assign m_start = m_start_q;
  assign m_abort = m_abort_q;
  assign m_addr  = m_addr_q;
  assign m_rw    = m_rw_q;
  assign m_wdata = m_wdata_q;
  assign busy    = busy_q;
  assign state   = state_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter: behavioural engine model, a
// scoreboard of expected {done, rdata, nack, tout} responses, and one task
// per scenario.
module tb_i2c_bus_arbiter;

  localparam int NREQ    = 4;
  localparam int ADDR_W  = 7;
  localparam int TIMEOUT = 1023;

  // Clock / reset
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ-1:0]        req_rw;
  logic [NREQ*8-1:0]      req_wdata;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        done;
  logic [7:0]             rdata;
  logic                   nack;
  logic                   tout;
  logic                   m_start;
  logic                   m_abort;
  logic [ADDR_W-1:0]      m_addr;
  logic                   m_rw;
  logic [7:0]             m_wdata;
  logic                   m_busy;
  logic                   m_done;
  logic                   m_ack_err;
  logic [7:0]             m_rdata;
  logic                   busy;
  logic [2:0]             state;

  i2c_bus_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(rst),
    .req(req), .req_addr(req_addr), .req_rw(req_rw), .req_wdata(req_wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .nack(nack), .tout(tout),
    .m_start(m_start), .m_abort(m_abort), .m_addr(m_addr), .m_rw(m_rw),
    .m_wdata(m_wdata), .m_busy(m_busy), .m_done(m_done),
    .m_ack_err(m_ack_err), .m_rdata(m_rdata), .busy(busy), .state(state)
  );

  // Scoreboard: {done one-hot, rdata, nack, tout}
  logic [NREQ+9:0] exp_q[$];
  logic [NREQ-1:0] gnt_log[$];
  logic [ADDR_W-1:0] addr_log[$];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc = 0, n_start = 0, n_abort = 0, n_done = 0;
  int start_cyc = 0, abort_cyc = 0, done_cyc = 0, mdone_cyc = 0;
  logic [NREQ-1:0] gnt_prev = '0;

  // Engine model controls: 0 = busy for eng_delay cycles then done,
  // 1 = busy and done in the same cycle, 2 = never completes.
  int         eng_mode = 0;
  int         eng_delay = 1;
  logic       eng_ack_err = 1'b0;
  logic [7:0] eng_rdata = 8'h00;

  // Engine model: drives its inputs just after the rising edge.
  initial begin
    m_busy = 1'b0; m_done = 1'b0; m_ack_err = 1'b0; m_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (m_start === 1'b1 && rst === 1'b0) begin
        @(posedge clk); #1;
        if (eng_mode == 1) begin
          m_busy = 1'b1; m_done = 1'b1; m_ack_err = eng_ack_err; m_rdata = eng_rdata;
          @(posedge clk); #1;
          m_busy = 1'b0; m_done = 1'b0; m_ack_err = 1'b0; m_rdata = 8'h00;
        end else if (eng_mode == 0) begin
          m_busy = 1'b1;
          repeat (eng_delay) begin @(posedge clk); #1; end
          m_done = 1'b1; m_ack_err = eng_ack_err; m_rdata = eng_rdata;
          @(posedge clk); #1;
          m_busy = 1'b0; m_done = 1'b0; m_ack_err = 1'b0; m_rdata = 8'h00;
        end else begin
          m_busy = 1'b1;
          for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            if (m_abort === 1'b1 || rst === 1'b1) break;
          end
          m_busy = 1'b0;
        end
      end
    end
  end

  // Advance one cycle, sample on the falling edge, score any done pulse and
  // drop the request of the requester that got it.
  task automatic tick();
    logic [NREQ+9:0] got;
    logic [NREQ+9:0] exp;
    @(negedge clk);
    cyc++;
    if (m_start === 1'b1) begin
      n_start++; start_cyc = cyc; addr_log.push_back(m_addr);
    end
    if (m_abort === 1'b1) begin n_abort++; abort_cyc = cyc; end
    if (m_done === 1'b1) mdone_cyc = cyc;
    if (gnt !== '0 && gnt_prev === '0) gnt_log.push_back(gnt);
    gnt_prev = gnt;
    if (done !== '0) begin
      done_cyc = cyc;
      n_done++;
      got = {done, rdata, nack, tout};
      n_assert++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_done got=%h expected none", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL sb_response got={done,rdata,nack,tout}=%h expected=%h", got, exp);
        end
      end
      req = req & ~done;
    end
  endtask

  task automatic run_until_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      tick();
      if (exp_q.size() == 0 && busy === 1'b0 && req === '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic set_fields(input int i, input logic [ADDR_W-1:0] a,
                            input logic rw, input logic [7:0] wd);
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_rw[i]                    = rw;
    req_wdata[i*8 +: 8]          = wd;
  endtask

  task automatic set_engine(input int mode, input int dly,
                            input logic ae, input logic [7:0] rd);
    eng_mode = mode; eng_delay = dly; eng_ack_err = ae; eng_rdata = rd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_assert++;
    if (state !== 3'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state state=%0d busy=%b expected 0/0", state, busy);
    end
    n_assert++;
    if ({gnt, done, rdata, nack, tout, m_start, m_abort, m_addr, m_rw, m_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs gnt=%b done=%b rdata=%h nack=%b tout=%b start=%b abort=%b addr=%h rw=%b wdata=%h expected all 0",
               gnt, done, rdata, nack, tout, m_start, m_abort, m_addr, m_rw, m_wdata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    int c_req, s0;
    bit ok;
    set_fields(0, 7'h50, 1'b0, 8'hAA);
    set_engine(0, 20, 1'b0, 8'h77);
    exp_q.push_back({4'b0001, 8'h00, 1'b0, 1'b0});
    s0 = n_start;
    req[0] = 1'b1;
    c_req = cyc;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (gnt !== '0) begin ok = 1'b1; break; end
    end
    n_assert++;
    if (!ok || gnt !== 4'b0001 || cyc != c_req + 1) begin
      n_fail++;
      $display("FAIL write_grant gnt=%b delay=%0d expected gnt=0001 delay=1", gnt, cyc - c_req);
    end
    n_assert++;
    if (m_start !== 1'b1) begin
      n_fail++;
      $display("FAIL write_start m_start=%b expected 1 in first granted cycle", m_start);
    end
    n_assert++;
    if (m_addr !== 7'h50 || m_rw !== 1'b0 || m_wdata !== 8'hAA) begin
      n_fail++;
      $display("FAIL write_latch addr=%h rw=%b wdata=%h expected 50/0/aa", m_addr, m_rw, m_wdata);
    end
    // Fields changing after grant must not reach the engine.
    set_fields(0, 7'h11, 1'b1, 8'h22);
    tick(); tick();
    n_assert++;
    if (m_addr !== 7'h50 || m_rw !== 1'b0 || m_wdata !== 8'hAA) begin
      n_fail++;
      $display("FAIL write_latch_hold addr=%h rw=%b wdata=%h expected 50/0/aa", m_addr, m_rw, m_wdata);
    end
    run_until_idle(100, ok);
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL write_complete idle=%b expected 1", ok); end
    n_assert++;
    if (n_start - s0 != 1) begin
      n_fail++;
      $display("FAIL write_start_count got=%0d expected 1", n_start - s0);
    end
    n_assert++;
    if (done_cyc - mdone_cyc != 1) begin
      n_fail++;
      $display("FAIL write_done_latency got=%0d expected 1", done_cyc - mdone_cyc);
    end
  endtask

  task automatic test_read_nack_ack();
    bit ok;
    set_fields(2, 7'h68, 1'b1, 8'h00);
    set_engine(0, 4, 1'b1, 8'h5A);
    exp_q.push_back({4'b0100, 8'h00, 1'b1, 1'b0});
    req[2] = 1'b1;
    run_until_idle(100, ok);
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL read_nack_complete idle=%b expected 1", ok); end
    repeat (3) tick();
    n_assert++;
    if (nack !== 1'b1 || rdata !== 8'h00 || tout !== 1'b0) begin
      n_fail++;
      $display("FAIL read_nack_hold nack=%b rdata=%h tout=%b expected 1/00/0", nack, rdata, tout);
    end
    set_engine(0, 4, 1'b0, 8'h3C);
    exp_q.push_back({4'b0100, 8'h3C, 1'b0, 1'b0});
    req[2] = 1'b1;
    run_until_idle(100, ok);
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL read_ack_complete idle=%b expected 1", ok); end
    repeat (3) tick();
    n_assert++;
    if (nack !== 1'b0 || rdata !== 8'h3C) begin
      n_fail++;
      $display("FAIL read_ack_hold nack=%b rdata=%h expected 0/3c", nack, rdata);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [15:0] g16;
    logic [27:0] a28;
    logic [7:0]  g8;
    rst = 1'b1; tick(); rst = 1'b0; tick();
    set_fields(0, 7'h10, 1'b1, 8'h00);
    set_fields(1, 7'h21, 1'b0, 8'h01);
    set_fields(2, 7'h32, 1'b1, 8'h00);
    set_fields(3, 7'h43, 1'b0, 8'h03);
    set_engine(0, 2, 1'b0, 8'h11);
    exp_q.push_back({4'b0001, 8'h11, 1'b0, 1'b0});
    exp_q.push_back({4'b0010, 8'h00, 1'b0, 1'b0});
    exp_q.push_back({4'b0100, 8'h11, 1'b0, 1'b0});
    exp_q.push_back({4'b1000, 8'h00, 1'b0, 1'b0});
    gnt_log.delete(); addr_log.delete();
    req = 4'b1111;
    run_until_idle(300, ok);
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL rr_complete idle=%b expected 1", ok); end
    g16 = '0; a28 = '0;
    for (int k = 0; k < gnt_log.size() && k < 4; k++) g16[k*4 +: 4] = gnt_log[k];
    for (int k = 0; k < addr_log.size() && k < 4; k++) a28[k*7 +: 7] = addr_log[k];
    n_assert++;
    if (gnt_log.size() != 4 || g16 !== 16'h8421) begin
      n_fail++;
      $display("FAIL rr_order grants=%0d log=%h expected 4 log=8421", gnt_log.size(), g16);
    end
    n_assert++;
    if (addr_log.size() != 4 || a28 !== {7'h43, 7'h32, 7'h21, 7'h10}) begin
      n_fail++;
      $display("FAIL rr_addr starts=%0d log=%h expected 4 log=%h", addr_log.size(), a28,
               {7'h43, 7'h32, 7'h21, 7'h10});
    end
    exp_q.push_back({4'b0001, 8'h11, 1'b0, 1'b0});
    exp_q.push_back({4'b1000, 8'h00, 1'b0, 1'b0});
    gnt_log.delete();
    req = 4'b1001;
    run_until_idle(200, ok);
    g8 = '0;
    for (int k = 0; k < gnt_log.size() && k < 2; k++) g8[k*4 +: 4] = gnt_log[k];
    n_assert++;
    if (!ok || gnt_log.size() != 2 || g8 !== 8'h81) begin
      n_fail++;
      $display("FAIL rr_wrap idle=%b grants=%0d log=%h expected 1/2/81", ok, gnt_log.size(), g8);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int s_ab;
    // Leave nack set beforehand so the timeout must clear it.
    set_fields(1, 7'h21, 1'b1, 8'h00);
    set_engine(0, 1, 1'b1, 8'h00);
    exp_q.push_back({4'b0010, 8'h00, 1'b1, 1'b0});
    req[1] = 1'b1;
    run_until_idle(100, ok);
    set_engine(2, 0, 1'b0, 8'h00);
    exp_q.push_back({4'b0010, 8'h00, 1'b0, 1'b1});
    s_ab = n_abort;
    req[1] = 1'b1;
    run_until_idle(1200, ok);
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL tout_complete idle=%b expected 1", ok); end
    n_assert++;
    if (n_abort - s_ab != 1 || abort_cyc - start_cyc != TIMEOUT + 1) begin
      n_fail++;
      $display("FAIL tout_abort pulses=%0d delay=%0d expected 1/%0d", n_abort - s_ab,
               abort_cyc - start_cyc, TIMEOUT + 1);
    end
    n_assert++;
    if (done_cyc != abort_cyc) begin
      n_fail++;
      $display("FAIL tout_done_align done_cyc=%0d abort_cyc=%0d expected equal", done_cyc, abort_cyc);
    end
    set_fields(2, 7'h32, 1'b0, 8'h5E);
    set_engine(0, 3, 1'b0, 8'h99);
    exp_q.push_back({4'b0100, 8'h00, 1'b0, 1'b0});
    req[2] = 1'b1;
    run_until_idle(100, ok);
    n_assert++;
    if (!ok || n_abort - s_ab != 1) begin
      n_fail++;
      $display("FAIL tout_recover idle=%b aborts=%0d expected 1/1", ok, n_abort - s_ab);
    end
  endtask

  task automatic test_fast_engine();
    bit ok;
    int c_req;
    set_fields(3, 7'h43, 1'b1, 8'h00);
    set_engine(1, 0, 1'b0, 8'hC3);
    exp_q.push_back({4'b1000, 8'hC3, 1'b0, 1'b0});
    c_req = cyc;
    req[3] = 1'b1;
    run_until_idle(50, ok);
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL fast_complete idle=%b expected 1", ok); end
    // Edge after req: grant/LAUNCH, WAIT_BUSY, then RESP carries done.
    n_assert++;
    if (done_cyc - c_req != 3) begin
      n_fail++;
      $display("FAIL fast_latency got=%0d expected 3", done_cyc - c_req);
    end
  endtask

  task automatic test_drop_mid();
    bit ok;
    int s_d;
    set_fields(1, 7'h21, 1'b0, 8'h44);
    set_engine(0, 5, 1'b0, 8'h00);
    exp_q.push_back({4'b0010, 8'h00, 1'b0, 1'b0});
    s_d = n_done;
    req[1] = 1'b1;
    repeat (4) tick();
    req[1] = 1'b0;
    run_until_idle(100, ok);
    n_assert++;
    if (!ok || n_done - s_d != 1) begin
      n_fail++;
      $display("FAIL drop_mid idle=%b dones=%0d expected 1/1", ok, n_done - s_d);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int s_d, s_a;
    logic [7:0] g8;
    set_fields(2, 7'h32, 1'b1, 8'h00);
    set_engine(2, 0, 1'b0, 8'h00);
    req[2] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (state === 3'd3) begin ok = 1'b1; break; end
    end
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL rstmid_reach state=%0d expected 3", state); end
    s_d = n_done; s_a = n_abort;
    rst = 1'b1;
    #1;
    n_assert++;
    if ({state, busy, gnt, done, rdata, nack, tout, m_start, m_abort, m_addr, m_rw, m_wdata} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs state=%0d busy=%b gnt=%b done=%b rdata=%h start=%b abort=%b addr=%h wdata=%h expected all 0",
               state, busy, gnt, done, rdata, m_start, m_abort, m_addr, m_wdata);
    end
    req = '0;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    n_assert++;
    if (n_done != s_d || n_abort != s_a) begin
      n_fail++;
      $display("FAIL rstmid_silent dones=%0d aborts=%0d expected 0/0", n_done - s_d, n_abort - s_a);
    end
    set_fields(1, 7'h21, 1'b0, 8'h12);
    set_fields(3, 7'h43, 1'b0, 8'h34);
    set_engine(0, 2, 1'b0, 8'h00);
    exp_q.push_back({4'b0010, 8'h00, 1'b0, 1'b0});
    exp_q.push_back({4'b1000, 8'h00, 1'b0, 1'b0});
    gnt_log.delete();
    req = 4'b1010;
    run_until_idle(200, ok);
    g8 = '0;
    for (int k = 0; k < gnt_log.size() && k < 2; k++) g8[k*4 +: 4] = gnt_log[k];
    n_assert++;
    if (!ok || gnt_log.size() != 2 || g8 !== 8'h82) begin
      n_fail++;
      $display("FAIL rstmid_ptr idle=%b grants=%0d log=%h expected 1/2/82", ok, gnt_log.size(), g8);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0; req_addr = '0; req_rw = '0; req_wdata = '0;
    test_reset();
    test_single_write();
    test_read_nack_ack();
    test_round_robin();
    test_timeout();
    test_fast_engine();
    test_drop_mid();
    test_reset_mid();
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover pending=%0d expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
